// File: rtl/alu_issue.sv
// ALU issue stage: decodes a MIPS instruction into ALU operands, op code and
// write-back control, then registers them with stall/flush handling.
module alu_issue #(
  parameter int NB_DATA      = 32,
  parameter int NB_OPERATION = 4,
  parameter int NB_REG_ADDR  = 5
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [31:0]             i_instruction,
  input  logic [NB_DATA-1:0]      i_rs_data,
  input  logic [NB_DATA-1:0]      i_rt_data,
  input  logic                    i_stall,
  input  logic                    i_flush,
  output logic                    o_valid,
  output logic [NB_DATA-1:0]      o_data_a,
  output logic [NB_DATA-1:0]      o_data_b,
  output logic [NB_OPERATION-1:0] o_op,
  output logic [NB_REG_ADDR-1:0]  o_rd_addr,
  output logic                    o_reg_write,
  output logic                    o_illegal
);

  localparam logic [NB_OPERATION-1:0] OP_ADD = NB_OPERATION'(4'b0000);
  localparam logic [NB_OPERATION-1:0] OP_SUB = NB_OPERATION'(4'b0001);
  localparam logic [NB_OPERATION-1:0] OP_AND = NB_OPERATION'(4'b0010);
  localparam logic [NB_OPERATION-1:0] OP_OR  = NB_OPERATION'(4'b0011);
  localparam logic [NB_OPERATION-1:0] OP_XOR = NB_OPERATION'(4'b0100);
  localparam logic [NB_OPERATION-1:0] OP_NOR = NB_OPERATION'(4'b0101);
  localparam logic [NB_OPERATION-1:0] OP_SRL = NB_OPERATION'(4'b0110);
  localparam logic [NB_OPERATION-1:0] OP_SLL = NB_OPERATION'(4'b0111);
  localparam logic [NB_OPERATION-1:0] OP_SRA = NB_OPERATION'(4'b1000);
  localparam logic [NB_OPERATION-1:0] OP_SLT = NB_OPERATION'(4'b1010);
  localparam logic [NB_OPERATION-1:0] OP_LUI = NB_OPERATION'(4'b1011);

  logic [5:0]              w_opcode;
  logic [4:0]              w_rt;
  logic [4:0]              w_rd;
  logic [4:0]              w_shamt;
  logic [5:0]              w_funct;
  logic [15:0]             w_imm;
  logic [NB_DATA-1:0]      w_imm_sext;
  logic [NB_DATA-1:0]      w_imm_zext;
  logic [NB_DATA-1:0]      w_shamt_ext;
  logic [NB_OPERATION-1:0] w_op;
  logic [NB_DATA-1:0]      w_a;
  logic [NB_DATA-1:0]      w_b;
  logic [NB_REG_ADDR-1:0]  w_dst;
  logic                    w_illegal;
  logic                    w_reg_write;

  // rs field feeds only through i_rs_data; its index bits are not needed here
  assign w_opcode    = i_instruction[31:26];
  assign w_rt        = i_instruction[20:16];
  assign w_rd        = i_instruction[15:11];
  assign w_shamt     = i_instruction[10:6];
  assign w_funct     = i_instruction[5:0];
  assign w_imm       = i_instruction[15:0];
  assign w_imm_sext  = {{(NB_DATA-16){w_imm[15]}}, w_imm};
  assign w_imm_zext  = NB_DATA'(w_imm);
  assign w_shamt_ext = NB_DATA'(w_shamt);

  always_comb begin
    w_op      = OP_ADD;
    w_a       = i_rs_data;
    w_b       = i_rt_data;
    w_dst     = NB_REG_ADDR'(w_rd);
    w_illegal = 1'b0;
    if (w_opcode == 6'h00) begin
      case (w_funct)
        6'h00: begin w_op = OP_SLL; w_a = w_shamt_ext; end
        6'h02: begin w_op = OP_SRL; w_a = w_shamt_ext; end
        6'h03: begin w_op = OP_SRA; w_a = w_shamt_ext; end
        6'h04: w_op = OP_SLL;
        6'h06: w_op = OP_SRL;
        6'h07: w_op = OP_SRA;
        6'h21: w_op = OP_ADD;
        6'h23: w_op = OP_SUB;
        6'h24: w_op = OP_AND;
        6'h25: w_op = OP_OR;
        6'h26: w_op = OP_XOR;
        6'h27: w_op = OP_NOR;
        6'h2A: w_op = OP_SLT;
        default: w_illegal = 1'b1;
      endcase
    end else begin
      w_dst = NB_REG_ADDR'(w_rt);
      case (w_opcode)
        6'h09: begin w_op = OP_ADD; w_b = w_imm_sext; end
        6'h0A: begin w_op = OP_SLT; w_b = w_imm_sext; end
        6'h0C: begin w_op = OP_AND; w_b = w_imm_zext; end
        6'h0D: begin w_op = OP_OR;  w_b = w_imm_zext; end
        6'h0E: begin w_op = OP_XOR; w_b = w_imm_zext; end
        6'h0F: begin w_op = OP_LUI; w_b = w_imm_zext; w_a = '0; end
        default: w_illegal = 1'b1;
      endcase
    end
    // Unsupported encodings issue a harmless zero ADD with no write-back
    if (w_illegal) begin
      w_op  = OP_ADD;
      w_a   = '0;
      w_b   = '0;
      w_dst = '0;
    end
  end

  assign w_reg_write = !w_illegal && (w_dst != '0);

  logic                    r_vld_p1;
  logic [NB_DATA-1:0]      r_data_a_p1;
  logic [NB_DATA-1:0]      r_data_b_p1;
  logic [NB_OPERATION-1:0] r_op_p1;
  logic [NB_REG_ADDR-1:0]  r_rd_addr_p1;
  logic                    r_reg_write_p1;
  logic                    r_illegal_p1;

  // Issue register: flush beats stall, stall holds everything
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_vld_p1       <= 1'b0;
      r_data_a_p1    <= '0;
      r_data_b_p1    <= '0;
      r_op_p1        <= OP_ADD;
      r_rd_addr_p1   <= '0;
      r_reg_write_p1 <= 1'b0;
      r_illegal_p1   <= 1'b0;
    end else if (i_flush) begin
      r_vld_p1       <= 1'b0;
      r_reg_write_p1 <= 1'b0;
      r_illegal_p1   <= 1'b0;
    end else if (!i_stall) begin
      if (i_valid) begin
        r_vld_p1       <= 1'b1;
        r_data_a_p1    <= w_a;
        r_data_b_p1    <= w_b;
        r_op_p1        <= w_op;
        r_rd_addr_p1   <= w_dst;
        r_reg_write_p1 <= w_reg_write;
        r_illegal_p1   <= w_illegal;
      end else begin
        r_vld_p1       <= 1'b0;
        r_reg_write_p1 <= 1'b0;
        r_illegal_p1   <= 1'b0;
      end
    end
  end

  assign o_valid     = r_vld_p1;
  assign o_data_a    = r_data_a_p1;
  assign o_data_b    = r_data_b_p1;
  assign o_op        = r_op_p1;
  assign o_rd_addr   = r_rd_addr_p1;
  assign o_reg_write = r_reg_write_p1;
  assign o_illegal   = r_illegal_p1;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: an instruction-level reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_alu_issue;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        vld   = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] rs    = '0;
  logic [31:0] rt    = '0;

  logic        o_valid;
  logic [31:0] o_data_a;
  logic [31:0] o_data_b;
  logic [3:0]  o_op;
  logic [4:0]  o_rd_addr;
  logic        o_reg_write;
  logic        o_illegal;

  int checks   = 0;
  int failures = 0;

  alu_issue #(.NB_DATA(32), .NB_OPERATION(4), .NB_REG_ADDR(5)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_valid       (vld),
    .i_instruction (instr),
    .i_rs_data     (rs),
    .i_rt_data     (rt),
    .i_stall       (stall),
    .i_flush       (flush),
    .o_valid       (o_valid),
    .o_data_a      (o_data_a),
    .o_data_b      (o_data_b),
    .o_op          (o_op),
    .o_rd_addr     (o_rd_addr),
    .o_reg_write   (o_reg_write),
    .o_illegal     (o_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t m = '0;

  // What the issue stage must present for one valid instruction
  function automatic exp_t model_decode(logic [31:0] ins, logic [31:0] rsv, logic [31:0] rtv);
    exp_t        e;
    logic        ok;
    logic [4:0]  dst;
    logic [31:0] sx;
    logic [31:0] zx;
    e  = '0;
    ok = 1'b1;
    e.v = 1'b1;
    e.a = rsv;
    e.b = rtv;
    sx  = {{16{ins[15]}}, ins[15:0]};
    zx  = {16'h0, ins[15:0]};
    if (ins[31:26] == 6'd0) begin
      dst = ins[15:11];
      case (ins[5:0])
        6'h00: begin e.op = 4'd7; e.a = {27'd0, ins[10:6]}; end
        6'h02: begin e.op = 4'd6; e.a = {27'd0, ins[10:6]}; end
        6'h03: begin e.op = 4'd8; e.a = {27'd0, ins[10:6]}; end
        6'h04: e.op = 4'd7;
        6'h06: e.op = 4'd6;
        6'h07: e.op = 4'd8;
        6'h21: e.op = 4'd0;
        6'h23: e.op = 4'd1;
        6'h24: e.op = 4'd2;
        6'h25: e.op = 4'd3;
        6'h26: e.op = 4'd4;
        6'h27: e.op = 4'd5;
        6'h2A: e.op = 4'd10;
        default: ok = 1'b0;
      endcase
    end else begin
      dst = ins[20:16];
      case (ins[31:26])
        6'h09: begin e.op = 4'd0;  e.b = sx; end
        6'h0A: begin e.op = 4'd10; e.b = sx; end
        6'h0C: begin e.op = 4'd2;  e.b = zx; end
        6'h0D: begin e.op = 4'd3;  e.b = zx; end
        6'h0E: begin e.op = 4'd4;  e.b = zx; end
        6'h0F: begin e.op = 4'd11; e.b = zx; e.a = 32'd0; end
        default: ok = 1'b0;
      endcase
    end
    if (ok) begin
      e.rd = dst;
      e.we = (dst != 5'd0);
    end else begin
      e.a   = '0;
      e.b   = '0;
      e.op  = 4'd0;
      e.rd  = 5'd0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else if (flush) begin
      m.v <= 1'b0; m.we <= 1'b0; m.ill <= 1'b0;
    end else if (!stall) begin
      if (vld) m <= model_decode(instr, rs, rt);
      else begin
        m.v <= 1'b0; m.we <= 1'b0; m.ill <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t got;
    got = {o_valid, o_data_a, o_data_b, o_op, o_rd_addr, o_reg_write, o_illegal};
    checks++;
    if (got !== m) begin
      failures++;
      $display("FAIL model_cmp t=%0t got v=%b a=%h b=%h op=%h rd=%0d we=%b ill=%b exp v=%b a=%h b=%h op=%h rd=%0d we=%b ill=%b",
               $time, got.v, got.a, got.b, got.op, got.rd, got.we, got.ill,
               m.v, m.a, m.b, m.op, m.rd, m.we, m.ill);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic s = 1'b0, input logic f = 1'b0);
    vld = v; instr = ins; rs = a; rt = b; stall = s; flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADD_7_8_9 = 32'h01093821;

  logic [31:0] vec_ins [12] = '{32'h00831004, 32'h00831027, 32'h00831023, 32'h0083102A,
                                32'h00831002, 32'h00831007, 32'h2862FF80, 32'h3062ABCD,
                                32'h3862ABCD, 32'h8C620000, 32'h00831008, 32'h00001000};

  initial begin
    tick(); tick();
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_op", {28'd0, o_op}, 32'd0);
    chk("reset_a", o_data_a, 32'd0);
    chk("reset_we", {31'd0, o_reg_write}, 32'd0);

    // first edge after reset release captures
    drive(1, ADD_7_8_9, 32'd100, 32'd23); rst = 1'b0; tick();
    chk("add_valid", {31'd0, o_valid}, 32'd1);
    chk("add_a", o_data_a, 32'd100);
    chk("add_b", o_data_b, 32'd23);
    chk("add_rd", {27'd0, o_rd_addr}, 32'd7);
    chk("add_we", {31'd0, o_reg_write}, 32'd1);

    drive(1, 32'h00021883, 32'h0, 32'h80000010); tick();
    chk("sra_op", {28'd0, o_op}, 32'h8);
    chk("sra_a", o_data_a, 32'd2);
    chk("sra_b", o_data_b, 32'h80000010);
    chk("sra_rd", {27'd0, o_rd_addr}, 32'd3);
    chk("sra_we", {31'd0, o_reg_write}, 32'd1);

    drive(1, 32'h2425FFFF, 32'd7, 32'h0); tick();
    chk("addiu_b", o_data_b, 32'hFFFFFFFF);
    chk("addiu_op", {28'd0, o_op}, 32'h0);
    chk("addiu_a", o_data_a, 32'd7);

    drive(1, 32'h3406FFFF, 32'h0, 32'h0); tick();
    chk("ori_b", o_data_b, 32'h0000FFFF);
    chk("ori_op", {28'd0, o_op}, 32'h3);

    drive(1, 32'h3C041234, 32'h55, 32'h66); tick();
    chk("lui_op", {28'd0, o_op}, 32'hB);
    chk("lui_a", o_data_a, 32'h0);
    chk("lui_b", o_data_b, 32'h00001234);
    chk("lui_rd", {27'd0, o_rd_addr}, 32'd4);
    chk("lui_we", {31'd0, o_reg_write}, 32'd1);

    drive(1, 32'h3C001234, 32'h55, 32'h66); tick();
    chk("lui_r0_we", {31'd0, o_reg_write}, 32'd0);
    chk("lui_r0_valid", {31'd0, o_valid}, 32'd1);

    drive(1, 32'h0000003F, 32'd5, 32'd6); tick();
    chk("ill_flag", {31'd0, o_illegal}, 32'd1);
    chk("ill_we", {31'd0, o_reg_write}, 32'd0);
    chk("ill_op", {28'd0, o_op}, 32'h0);
    chk("ill_valid", {31'd0, o_valid}, 32'd1);
    chk("ill_a", o_data_a, 32'h0);

    drive(1, 32'h2862FF80, 32'h3, 32'h4); tick();
    chk("slti_op", {28'd0, o_op}, 32'hA);
    chk("slti_b", o_data_b, 32'hFFFFFF80);

    for (int i = 0; i < 12; i++) begin
      drive(1, vec_ins[i], 32'h1000 + i, 32'hF0F0_0000 + i); tick();
    end

    drive(0, ADD_7_8_9, 32'd1, 32'd2); tick();
    chk("idle_valid", {31'd0, o_valid}, 32'd0);

    drive(1, ADD_7_8_9, 32'd100, 32'd23); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h00831027, 32'd9 + i, 32'd77 - i, 1'b1); tick();
      chk("stall_a", o_data_a, 32'd100);
      chk("stall_b", o_data_b, 32'd23);
      chk("stall_op_rd", {23'd0, o_op, o_rd_addr}, {23'd0, 4'd0, 5'd7});
      chk("stall_v_we", {30'd0, o_valid, o_reg_write}, 32'd3);
    end
    drive(1, 32'h00831027, 32'd9, 32'd9, 1'b1, 1'b1); tick();
    chk("flush_stall_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_stall_we", {31'd0, o_reg_write}, 32'd0);
    chk("flush_hold_a", o_data_a, 32'd100);

    drive(1, 32'h0000003F, 32'd1, 32'd1); tick();
    drive(1, ADD_7_8_9, 32'd3, 32'd4, 1'b0, 1'b1); tick();
    chk("flush_ill", {30'd0, o_valid, o_illegal}, 32'd0);

    // asynchronous reset in the middle of a cycle
    drive(1, ADD_7_8_9, 32'd100, 32'd23); tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_a", o_data_a, 32'd0);
    chk("async_rst_b", o_data_b, 32'd0);
    chk("async_rst_rd", {27'd0, o_rd_addr}, 32'd0);
    tick();
    drive(0, 32'h0, 32'h0, 32'h0); rst = 1'b0; tick();

    drive(1, ADD_7_8_9, 32'd100, 32'd23); tick();
    drive(1, ADD_7_8_9, 32'd100, 32'd23, 1'b1); tick();
    #2 rst = 1'b1;
    tick();
    drive(0, ADD_7_8_9, 32'd100, 32'd23); rst = 1'b0; tick();
    chk("rst_stall_a", o_data_a, 32'd0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter NB_DATA, 32, operand/result width.
REQ-002 Parameter NB_OPERATION, 4, ALU op-code width.
REQ-003 Parameter NB_REG_ADDR, 5, register-address width.
REQ-004 One clock; reset is asynchronous and active-high. Ports: i_clock and i_reset.
REQ-005 i_clock  input  1  rising-edge clock.
REQ-006 i_reset  input  1  asynchronous active-high reset.
REQ-007 i_valid  input  1  i_instruction and operands are valid this cycle.
REQ-008 i_instruction  input  32  MIPS instruction word: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] imm[15:0].
REQ-009 i_rs_data, i_rt_data  input  NB_DATA  register-file read values for rs and rt.
REQ-010 i_stall  input  1  downstream is not ready; hold all outputs.
REQ-011 i_flush  input  1  discard the instruction in flight.
REQ-012 o_valid  output  1  outputs describe a live ALU operation.
REQ-013 o_data_a, o_data_b  output  NB_DATA  ALU operands; shift amount is taken from o_data_a[4:0] and shifted value from o_data_b.
REQ-014 o_op  output  NB_OPERATION  ALU code: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOR 0101, SRL 0110, SLL 0111, SRA 1000, SLT 1010, LUI 1011.
REQ-015 o_rd_addr  output  NB_REG_ADDR  destination register.
REQ-016 o_reg_write  output  1  result is to be written back.
REQ-017 o_illegal  output  1  captured instruction is unsupported.

Function
REQ-018 Registered stage. Latency is 1 cycle: inputs captured on a rising edge appear on the outputs after that edge.
REQ-019 R-type decode (op=0x00), keyed on funct:
- 0x00 SLL, 0x02 SRL, 0x03 SRA: a={zeros,shamt}, b=rt.
- 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: a=rs, b=rt; ops SLL, SRL, SRA respectively.
- 0x21 ADD, 0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT: a=rs, b=rt.
- Destination is rd.
REQ-020 I-type decode, a=rs, destination rt:
- 0x09 ADD and 0x0A SLT: b=sign-extended imm.
- 0x0C AND, 0x0D OR, 0x0E XOR: b=zero-extended imm.
- 0x0F LUI: b=zero-extended imm, a=0.
REQ-021 Any other op/funct:
- o_illegal=1, o_op=ADD, o_reg_write=0, o_data_a=o_data_b=0.
- o_valid follows i_valid.
REQ-022 o_reg_write=1 only when the capture is valid, the instruction is legal and the destination is not 0.
REQ-023 Priority order is reset > i_flush > i_stall > capture.
REQ-024 When i_flush=1, next edge: o_valid=0, o_reg_write=0, o_illegal=0. This applies even if i_stall=1. Data, op and address fields hold.
REQ-025 When i_stall=1 and i_flush=0, all outputs hold their values. The input is not consumed; upstream holds it.
REQ-026 When i_stall=0 and i_valid=0, next edge: o_valid=0, o_reg_write=0, o_illegal=0. Other fields hold.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 When i_reset is asserted, all outputs go to 0 immediately and asynchronously. Therefore o_op=ADD.
REQ-029 After i_reset deasserts, the first capture happens on the first rising edge.
REQ-030 A reset that arrives during a stall discards the held instruction.

Verification
REQ-031 Reset test: assert i_reset mid-cycle with o_valid=1. All outputs are 0 before the next edge.
REQ-032 SRA test: instruction 0x00021883 (sra $3,$2,2), rt=0x80000010, valid.
- Next cycle: o_op=1000, o_data_a=2, o_data_b=0x80000010, o_rd_addr=3, o_reg_write=1.
REQ-033 Immediate-extension test:
- Addiu $5,$1,-1 (0x2425FFFF), rs=7: o_data_b=0xFFFFFFFF, o_op=0000.
- Ori with imm=0xFFFF: o_data_b=0x0000FFFF, o_op=0011.
REQ-034 LUI test: lui $4,0x1234 (0x3C041234).
- o_op=1011, o_data_a=0, o_data_b=0x00001234, o_rd_addr=4.
- Writes to $0 force o_reg_write=0.
REQ-035 Stall and flush test:
- Capture an ADD, then hold i_stall=1 for 3 cycles while changing the inputs: outputs stay constant.
- Assert i_flush together with stall: o_valid=0 next cycle.
REQ-036 Illegal-instruction test: instruction 0x0000003F with valid.
- o_illegal=1, o_reg_write=0, o_op=0000, o_valid=1.
